// File: rtl/tx_sched.sv
// tx_sched: round-robin 4-requester arbiter feeding an 8E1/8O1 serial framer.
// One byte per frame; the line idles high between frames.
module tx_sched #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        serial_out,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [7:0]  cnt;
  logic [2:0]  bitc;
  logic [7:0]  dat;
  logic [1:0]  rr_ptr;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;
  logic        grant;
  logic        last_per;

  assign last_per = (cnt == 8'(CLKS_PER_BIT - 1));

  // Search downward so the requester closest to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant = (state == IDLE) && found && !rst;

  always_comb begin
    req_ready = 4'b0000;
    if (grant)
      req_ready = 4'b0001 << pick;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (grant) nxt = START;
      START:  if (last_per) nxt = DATA;
      DATA:   if (last_per && bitc == 3'd7) nxt = PARITY;
      PARITY: if (last_per) nxt = STOP;
      STOP:   if (last_per) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    serial_out = 1'b1;
    unique case (state)
      IDLE:   serial_out = 1'b1;
      START:  serial_out = 1'b0;
      DATA:   serial_out = dat[bitc];
      PARITY: serial_out = (^dat) ^ PARITY_ODD;
      STOP:   serial_out = 1'b1;
      default: serial_out = 1'b1;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && last_per;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      bitc     <= 3'd0;
      dat      <= 8'd0;
      rr_ptr   <= 2'd0;
      grant_id <= 2'd0;
    end else begin
      state <= nxt;
      if (grant) begin
        dat      <= req_data[{pick, 3'b000} +: 8];
        grant_id <= pick;
        rr_ptr   <= pick + 2'd1;
        cnt      <= 8'd0;
        bitc     <= 3'd0;
      end else if (state != IDLE) begin
        cnt <= last_per ? 8'd0 : cnt + 8'd1;
        if (state == DATA && last_per)
          bitc <= bitc + 3'd1;
      end
    end
  end

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity (parity bit = XOR of the 8 data bits); 1 selects the inverse of that XOR.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req_valid, input, 4 bits: bit i set means requester i has a byte to send.
REQ-006 Port req_data, input, 32 bits: byte for requester i on bits [8i+7:8i].
REQ-007 Port req_ready, output, 4 bits: one-hot accept pulse; a transfer occurs on the cycle where req_valid[i] and req_ready[i] are both high.
REQ-008 Port serial_out, output, 1 bit: serial line, idle high.
REQ-009 Port busy, output, 1 bit: high while a frame is on the line.
REQ-010 Port grant_id, output, 2 bits: index of the requester owning the current or last frame.
REQ-011 Port frame_done, output, 1 bit: single-cycle pulse at frame end.

Function
REQ-012 State machine states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-013 IDLE behaviour: serial_out=1 and busy=0.
REQ-014 IDLE grant: if any req_valid bit is set, the block SHALL pick one requester round-robin starting at pointer rr_ptr.
- Assert req_ready for that requester only, in that same cycle.
- Latch its byte.
- Load grant_id with its index.
- Set rr_ptr to (index+1) mod 4.
- Go to START on the next cycle.
REQ-015 req_ready SHALL never be asserted outside IDLE, and SHALL never be asserted for a requester whose req_valid is low.
REQ-016 START: serial_out=0 for CLKS_PER_BIT cycles.
REQ-017 DATA: serial_out drives the latched byte LSB first, each bit for CLKS_PER_BIT cycles; a 3-bit bit counter steps 0..7.
REQ-018 PARITY: serial_out = parity of the latched byte per PARITY_ODD, for CLKS_PER_BIT cycles.
REQ-019 STOP: serial_out=1 for CLKS_PER_BIT cycles; frame_done=1 only in the last STOP cycle; return to IDLE next cycle.
REQ-020 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 otherwise.
REQ-021 Frame timing: with the grant cycle at t0, START SHALL begin at t1, frame_done SHALL fire at t0+11*CLKS_PER_BIT, and the earliest next grant SHALL be the following cycle. This gives a minimum 1-cycle idle-high gap between frames.
REQ-022 The latched byte SHALL be unaffected by changes on req_data or req_valid after the grant.
REQ-023 A requester that drops req_valid before being granted SHALL simply be skipped, with no error.
REQ-024 A bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; CLKS_PER_BIT=1 SHALL give one cycle per bit with no extra stall.
REQ-025 rr_ptr SHALL wrap from 3 to 0; a sole active requester SHALL be granted back-to-back frames.

Reset
REQ-026 When rst is high at a clock edge, on that edge the block SHALL:
- Enter IDLE.
- Drive serial_out=1, busy=0, req_ready=0, frame_done=0, grant_id=0.
- Set rr_ptr=0 and clear the bit counter, period counter and latched byte.
REQ-027 rst SHALL take priority over all other inputs, including in the same cycle as a grant.
REQ-028 Reset mid-frame SHALL abort the frame: no frame_done, the line goes high on the reset edge, and the aborted requester is not re-served automatically.

Verification
REQ-029 CLKS_PER_BIT=1, PARITY_ODD=0, req_valid=0001, req_data[7:0]=8'hA5:
- req_ready=0001 in the grant cycle t0.
- serial_out from t1 = 0,1,0,1,0,0,1,0,1,0,1.
- frame_done at t11, busy high t1..t11.
REQ-030 After reset, req_valid=1111 held continuously: grants in order 0,1,2,3,0, each separated by 12 cycles.
- With req_valid=1010 after granting 2: next grants 3 then 1.
REQ-031 Parity check with data 8'h07: parity bit=1 with PARITY_ODD=0, and 0 with PARITY_ODD=1; data 8'h00 gives parity 0 with PARITY_ODD=0.
REQ-032 CLKS_PER_BIT=3, data 8'hFF:
- START low at t1..t3.
- Each data bit high for 3 cycles, t4..t27.
- Parity 0 at t28..t30.
- STOP at t31..t33, frame_done at t33 only.
REQ-033 Assert rst during DATA bit 3:
- On that edge serial_out=1, busy=0, grant_id=0, and no frame_done.
- Then req_valid=0100 is granted as the first request after reset release.
REQ-034 Assert req_valid[1] for 1 cycle while busy, then deassert: no req_ready[1] is ever pulsed and the line stays idle high after the current frame.
